// File: rtl/regfile_mp.sv
// Multi-port register file: N read / M write ports, write-to-read bypass, optional zero r0.
// Define REGFILE_SCOREBOARD_EN to add the busy scoreboard (alloc_add/alloc_flag/rbusy).

module regfile_mp_rd_lane #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int NUM_WR  = 1,
   parameter int DEPTH   = 8,
   parameter int ZERO_R0 = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           active,
   input  logic [ADDR_W-1:0]              raddr,
   input  logic [DEPTH-1:0][DATA_W-1:0]   regs,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wadd,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wdata,
   input  logic [NUM_WR-1:0]              wq,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic [DEPTH-1:0]               busy_clr,
   output logic                           rbusy,
`endif
   output logic [DATA_W-1:0]              rdata,
   output logic                           rvalid
);
   logic [DATA_W-1:0] rd_nxt;

   // Ascending scan so the highest-index matching write port supplies the bypass.
   always_comb begin
      rd_nxt = regs[raddr];
      for (int w = 0; w < NUM_WR; w++)
         if (wq[w] && wadd[w] == raddr) rd_nxt = wdata[w];
      if (ZERO_R0 != 0 && raddr == '0) rd_nxt = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= active;
         if (active) rdata <= rd_nxt;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   always_ff @(posedge clock) begin
      if (reset)       rbusy <= 1'b0;
      else if (active) rbusy <= busy_clr[raddr];
   end
`endif
endmodule

module regfile_mp #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 1,
   parameter int ZERO_R0 = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      exec,
   input  logic                      enable,
   input  logic [NUM_RD*ADDR_W-1:0]  radd,
   output logic [NUM_RD*DATA_W-1:0]  rdata,
   output logic [NUM_RD-1:0]         rvalid,
   input  logic [NUM_WR*ADDR_W-1:0]  wadd,
   input  logic [NUM_WR*DATA_W-1:0]  wdata,
`ifdef REGFILE_SCOREBOARD_EN
   input  logic [ADDR_W-1:0]         alloc_add,
   input  logic                      alloc_flag,
   output logic [NUM_RD-1:0]         rbusy,
`endif
   input  logic [NUM_WR-1:0]         wflag
);
   localparam int DEPTH = 1 << ADDR_W;

   logic                          active;
   logic [NUM_WR-1:0][ADDR_W-1:0] wadd_v;
   logic [NUM_WR-1:0][DATA_W-1:0] wdata_v;
   logic [NUM_WR-1:0]             wq;
   logic [NUM_RD-1:0][ADDR_W-1:0] radd_v;
   logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;
   logic [DEPTH-1:0][DATA_W-1:0]  regs;

   assign active  = !reset && !exec && enable;
   assign wadd_v  = wadd;
   assign wdata_v = wdata;
   assign radd_v  = radd;
   assign rdata   = rdata_v;

   // Writes to r0 are squashed here so neither the array nor the bypass sees them.
   always_comb begin
      for (int w = 0; w < NUM_WR; w++)
         wq[w] = wflag[w] && !(ZERO_R0 != 0 && wadd_v[w] == '0);
   end

   // Later loop iterations override earlier ones: higher write port wins.
   always_ff @(posedge clock) begin
      if (reset) regs <= '0;
      else if (active)
         for (int w = 0; w < NUM_WR; w++)
            if (wq[w]) regs[wadd_v[w]] <= wdata_v[w];
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] busy, busy_clr, busy_nxt;

   always_comb begin
      busy_clr = busy;
      for (int w = 0; w < NUM_WR; w++)
         if (wq[w]) busy_clr[wadd_v[w]] = 1'b0;
      busy_nxt = busy_clr;
      if (alloc_flag && !(ZERO_R0 != 0 && alloc_add == '0)) busy_nxt[alloc_add] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)       busy <= '0;
      else if (active) busy <= busy_nxt;
   end
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_mp_rd_lane #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR),
         .DEPTH(DEPTH), .ZERO_R0(ZERO_R0)
      ) u_lane (
         .clock   (clock),
         .reset   (reset),
         .active  (active),
         .raddr   (radd_v[k]),
         .regs    (regs),
         .wadd    (wadd_v),
         .wdata   (wdata_v),
         .wq      (wq),
`ifdef REGFILE_SCOREBOARD_EN
         .busy_clr(busy_clr),
         .rbusy   (rbusy[k]),
`endif
         .rdata   (rdata_v[k]),
         .rvalid  (rvalid[k])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (plain and zero-r0), array model plus directed literals.
module tb_regfile_mp;
   logic        clock = 1'b0;
   logic        reset, exec, enable;
   logic [5:0]  radd, wadd;
   logic [31:0] wdata;
   logic [1:0]  wflag;
   logic [2:0]  alloc_add;
   logic        alloc_flag;
   logic [31:0] rdata_a, rdata_z;
   logic [1:0]  rvalid_a, rvalid_z;
`ifdef REGFILE_SCOREBOARD_EN
   logic [1:0]  rbusy_a, rbusy_z;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_R0(0)) u_dut (
      .clock(clock), .reset(reset), .exec(exec), .enable(enable),
      .radd(radd), .rdata(rdata_a), .rvalid(rvalid_a),
      .wadd(wadd), .wdata(wdata),
`ifdef REGFILE_SCOREBOARD_EN
      .alloc_add(alloc_add), .alloc_flag(alloc_flag), .rbusy(rbusy_a),
`endif
      .wflag(wflag));

   regfile_mp #(.NUM_RD(2), .NUM_WR(2), .ZERO_R0(1)) u_z (
      .clock(clock), .reset(reset), .exec(exec), .enable(enable),
      .radd(radd), .rdata(rdata_z), .rvalid(rvalid_z),
      .wadd(wadd), .wdata(wdata),
`ifdef REGFILE_SCOREBOARD_EN
      .alloc_add(alloc_add), .alloc_flag(alloc_flag), .rbusy(rbusy_z),
`endif
      .wflag(wflag));

   // Model: index d=0 is the plain file, d=1 the zero-r0 file.
   logic [15:0] mem    [2][8];
   bit          busy   [2][8];
   logic [15:0] exp_rd [2][2];
   bit          exp_v  [2][2];
   bit          exp_rb [2][2];

   always @(posedge clock) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin mem[d][i] = 16'h0; busy[d][i] = 0; end
            for (int k = 0; k < 2; k++) begin exp_rd[d][k] = 16'h0; exp_v[d][k] = 0; exp_rb[d][k] = 0; end
         end
      end else if (exec || !enable) begin
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < 2; k++) exp_v[d][k] = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
               int ra;
               logic [15:0] v;
               bit b;
               ra = int'(radd[k*3 +: 3]);
               v = mem[d][ra];
               b = busy[d][ra];
               for (int w = 0; w < 2; w++)
                  if (wflag[w] && !(d == 1 && wadd[w*3 +: 3] == 3'd0) && int'(wadd[w*3 +: 3]) == ra) begin
                     v = wdata[w*16 +: 16];
                     b = 0;
                  end
               if (d == 1 && ra == 0) v = 16'h0;
               exp_rd[d][k] = v; exp_v[d][k] = 1; exp_rb[d][k] = b;
            end
            for (int w = 0; w < 2; w++)
               if (wflag[w] && !(d == 1 && wadd[w*3 +: 3] == 3'd0)) begin
                  mem[d][wadd[w*3 +: 3]] = wdata[w*16 +: 16];
                  busy[d][wadd[w*3 +: 3]] = 0;
               end
            if (alloc_flag && !(d == 1 && alloc_add == 3'd0)) busy[d][alloc_add] = 1;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (rdata_a[k*16 +: 16] !== exp_rd[0][k]) begin errors++;
               $display("FAIL model rdata_a[%0d] got %h want %h t=%0t", k, rdata_a[k*16 +: 16], exp_rd[0][k], $time); end
            if (rdata_z[k*16 +: 16] !== exp_rd[1][k]) begin errors++;
               $display("FAIL model rdata_z[%0d] got %h want %h t=%0t", k, rdata_z[k*16 +: 16], exp_rd[1][k], $time); end
            if (rvalid_a[k] !== exp_v[0][k]) begin errors++;
               $display("FAIL model rvalid_a[%0d] got %b want %b t=%0t", k, rvalid_a[k], exp_v[0][k], $time); end
            if (rvalid_z[k] !== exp_v[1][k]) begin errors++;
               $display("FAIL model rvalid_z[%0d] got %b want %b t=%0t", k, rvalid_z[k], exp_v[1][k], $time); end
`ifdef REGFILE_SCOREBOARD_EN
            checks += 2;
            if (rbusy_a[k] !== exp_rb[0][k]) begin errors++;
               $display("FAIL model rbusy_a[%0d] got %b want %b t=%0t", k, rbusy_a[k], exp_rb[0][k], $time); end
            if (rbusy_z[k] !== exp_rb[1][k]) begin errors++;
               $display("FAIL model rbusy_z[%0d] got %b want %b t=%0t", k, rbusy_z[k], exp_rb[1][k], $time); end
`endif
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic drive(input logic [1:0] wf, input logic [2:0] wa0, input logic [15:0] wd0,
                        input logic [2:0] wa1, input logic [15:0] wd1,
                        input logic [2:0] ra0, input logic [2:0] ra1);
      wflag = wf; wadd = {wa1, wa0}; wdata = {wd1, wd0}; radd = {ra1, ra0};
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1; exec = 1'b0; enable = 1'b1;
      radd = '0; wadd = '0; wdata = '0; wflag = '0;
      alloc_add = '0; alloc_flag = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("reset_rvalid", {30'd0, rvalid_a}, 32'd0);
      reset = 1'b0;

      // Fill, then reset with a write in flight: everything reads back zero.
      for (int i = 0; i < 8; i++) drive(2'b01, 3'(i), 16'h1000 + 16'(i), 0, 0, 0, 0);
      reset = 1'b1;
      drive(2'b01, 3, 16'h7777, 0, 0, 3, 3);
      chk("reset_hold_rvalid", {30'd0, rvalid_a}, 32'd0);
      chk("reset_rdata", rdata_a, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 0, 0, 0, 0, 3'(2*i), 3'(2*i+1));
         chk("post_reset_rd", rdata_a, 32'd0);
         chk("post_reset_rvalid", {30'd0, rvalid_a}, 32'd3);
      end

      drive(2'b01, 3, 16'hBEEF, 0, 0, 0, 0);
      drive(2'b00, 0, 0, 0, 0, 3, 3);
      chk("beef_rd", rdata_a, {16'hBEEF, 16'hBEEF});
      chk("beef_rvalid", {30'd0, rvalid_a}, 32'd3);

      drive(2'b01, 2, 16'h00AA, 0, 0, 0, 0);
      drive(2'b01, 5, 16'h1234, 0, 0, 5, 2);
      chk("bypass_rd", rdata_a, {16'h00AA, 16'h1234});

      drive(2'b11, 4, 16'h1111, 4, 16'h2222, 4, 4);
      chk("wprio_bypass", rdata_a, {16'h2222, 16'h2222});
      drive(2'b00, 0, 0, 0, 0, 4, 4);
      chk("wprio_array", rdata_a, {16'h2222, 16'h2222});

      drive(2'b01, 1, 16'h0101, 0, 0, 1, 1);
      drive(2'b00, 0, 0, 0, 0, 1, 1);
      chk("r1_rd", rdata_a, {16'h0101, 16'h0101});
      exec = 1'b1;
      drive(2'b01, 1, 16'hFFFF, 0, 0, 3, 3);
      chk("exec_hold_rd", rdata_a, {16'h0101, 16'h0101});
      chk("exec_hold_rvalid", {30'd0, rvalid_a}, 32'd0);
      exec = 1'b0; enable = 1'b0;
      drive(2'b01, 1, 16'hFFFF, 0, 0, 3, 3);
      chk("en_hold_rd", rdata_a, {16'h0101, 16'h0101});
      chk("en_hold_rvalid", {30'd0, rvalid_a}, 32'd0);
      enable = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 1, 1);
      chk("r1_after_hold", rdata_a, {16'h0101, 16'h0101});

      drive(2'b01, 0, 16'h5555, 0, 0, 0, 0);
      chk("r0_plain_bypass", rdata_a, {16'h5555, 16'h5555});
      chk("r0_zero_bypass", rdata_z, 32'd0);
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("r0_plain_array", rdata_a, {16'h5555, 16'h5555});
      chk("r0_zero_array", rdata_z, 32'd0);

`ifdef REGFILE_SCOREBOARD_EN
      alloc_flag = 1'b1; alloc_add = 3'd6;
      drive(2'b00, 0, 0, 0, 0, 6, 6);
      alloc_flag = 1'b0;
      chk("alloc_same_cycle", {30'd0, rbusy_a}, 32'd0);
      drive(2'b00, 0, 0, 0, 0, 6, 6);
      chk("alloc_busy", {30'd0, rbusy_a}, 32'd3);
      drive(2'b01, 6, 16'hABCD, 0, 0, 6, 6);
      chk("wr_clears_busy", {30'd0, rbusy_a}, 32'd0);
      chk("wr_busy_data", rdata_a, {16'hABCD, 16'hABCD});
      alloc_flag = 1'b1; alloc_add = 3'd0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      alloc_flag = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("alloc_r0_plain", {30'd0, rbusy_a}, 32'd3);
      chk("alloc_r0_zero", {30'd0, rbusy_z}, 32'd0);
`endif

      // Mixed traffic checked by the model only.
      for (int i = 0; i < 120; i++) begin
         reset      = ($urandom_range(0, 31) == 0);
         exec       = ($urandom_range(0, 7) == 0);
         enable     = ($urandom_range(0, 7) != 0);
         alloc_flag = ($urandom_range(0, 3) == 0);
         alloc_add  = 3'($urandom_range(0, 7));
         drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'($urandom),
               3'($urandom_range(0, 7)), 16'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      reset = 1'b0; exec = 1'b0; enable = 1'b1; alloc_flag = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(negedge clock); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the simpleCPU datapath. It generalises the 8x16 two-read/one-write file to configurable width, depth and port counts. It adds multi-write priority, write-to-read bypass on every read port, an optional hard-wired zero register and a per-read valid strobe. It sits between decode (read addresses) and writeback (write ports) and keeps the existing exec/enable hold semantics.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2); the higher index has priority
ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clock  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; has priority over all other inputs
exec  in  1  1 = freeze the whole file (no read, no write)
enable  in  1  0 = freeze the whole file
radd  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  registered read data, one slice per port
rvalid  out  NUM_RD  1-cycle pulse: rdata slice updated this cycle
wadd  in  NUM_WR*ADDR_W  write addresses
wdata  in  NUM_WR*DATA_W  write data
wflag  in  NUM_WR  write enable per write port

Behaviour:
- Reset (clock edge with reset=1): all DEPTH registers, all rdata = 0; rvalid = 0. exec and enable are ignored. Reset asserted mid-operation discards any same-cycle write.
- Hold (reset=0 and exec=1, or enable=0): array, rdata and busy state unchanged; rvalid = 0.
- Active cycle (reset=0, exec=0, enable=1):
  - Each port w with wflag[w]=1 writes wdata[w] to reg[wadd[w]]. If two ports target the same address, port NUM_WR-1 wins.
  - Each read port k: rdata[k] <= bypass value, else reg[radd[k]] (pre-edge value). The bypass value is wdata of the highest-index port with wflag=1 and wadd == radd[k]. rvalid[k] <= 1.
  - Read latency: 1 clock from address to rdata. A write is visible through the array on the next active cycle and through the bypass in the same cycle.
- ZERO_R0=1: writes to address 0 are dropped (no array update, no bypass). Reads of address 0 return 0.
- Widths: no arithmetic. Addresses always lie in range because DEPTH = 2**ADDR_W.
- Multiple read ports with the same address return identical data.

Optional Feature:
Macro REGFILE_SCOREBOARD_EN.
- Defined:
  - Adds ports alloc_add (in, ADDR_W), alloc_flag (in, 1) and rbusy (out, NUM_RD).
  - Adds an internal busy[DEPTH] vector, cleared to 0 on reset.
  - On an active cycle, every winning write clears busy[wadd]. Then alloc_flag=1 sets busy[alloc_add]; set wins over a same-cycle clear.
  - rbusy[k] <= busy[radd[k]] after that cycle's write clears and before that cycle's alloc set. A register written this cycle therefore reads not-busy, consistent with the bypass.
  - Hold cycles freeze busy and rbusy. rbusy resets to 0.
  - With ZERO_R0=1, allocs to address 0 are ignored.
- Undefined: none of these ports or state exist; behaviour is exactly as above.

Test Plan:
- Reset with prior contents -> all reads of addr 0..7 return 0x0000, and rvalid stays 0 during reset.
- Write 0xBEEF to r3, then read r3 on ports 0 and 1 next cycle -> both rdata = 0xBEEF, rvalid = 2'b11.
- Same cycle: write r5 = 0x1234, radd0 = 5, radd1 = 2 (r2 = 0x00AA) -> rdata0 = 0x1234 (bypass), rdata1 = 0x00AA.
- NUM_WR=2, both ports write r4 (0x1111 on port 0, 0x2222 on port 1) while reading r4 -> rdata = 0x2222; next read of r4 = 0x2222.
- exec=1 or enable=0 with wflag=1, wadd=1, wdata=0xFFFF -> r1 unchanged, rdata held, rvalid = 0; a later read of r1 shows the old value.
- ZERO_R0=1: write 0x5555 to r0 while reading r0 -> rdata = 0. Scoreboard build: alloc r6, read r6 -> rbusy = 1; write r6 while reading it -> rbusy = 0 and rdata = the new data.
